// File: rtl/hdmi_island_scheduler_pkg.sv
// Shared definitions for the HDMI data-island scheduler.
//   packetType_e    : packet-type codes driven on packetType
//   islandState_e   : island framing FSM states
//   framing lengths : preamble, guard band, packet slot, fixed island overhead
//   audioSamples()  : samples carried by one AUDIO packet for a given FIFO level
package hdmi_island_scheduler_pkg;

  typedef enum logic [2:0] {
    PKT_NULL     = 3'd0,
    PKT_ACR      = 3'd1,
    PKT_AUDIO    = 3'd2,
    PKT_AVI      = 3'd3,
    PKT_AUDIO_IF = 3'd4,
    PKT_SPD      = 3'd5
  } packetType_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PREAMBLE    = 3'd1,
    ST_LEAD_GUARD  = 3'd2,
    ST_PACKET      = 3'd3,
    ST_TRAIL_GUARD = 3'd4
  } islandState_e;

  localparam int PREAMBLE_LEN    = 8;
  localparam int GUARD_LEN       = 2;
  localparam int SLOT_LEN        = 32;
  localparam int ISLAND_OVERHEAD = PREAMBLE_LEN + 2 * GUARD_LEN;

  // An audio sample packet carries at most four samples.
  function automatic logic [2:0] audioSamples(input logic [3:0] sampleCount);
    return (sampleCount > 4'd4) ? 3'd4 : sampleCount[2:0];
  endfunction

endpackage

// File: rtl/hdmi_packet_arbiter.sv
// Pending-packet bookkeeping and fixed-priority grant for the island scheduler.
//   pixelClock, resetN : clock and async active-low reset
//   acrRequest         : one-cycle pulse, arms the sticky ACR flag
//   vSyncRise          : one-cycle pulse, arms AVI / AUDIO_IF / SPD flags
//   sampleCount        : audio FIFO level; AUDIO is requested while non-zero
//   grantTake          : the current grant is being placed into a slot; clear its flag
//   anyPending         : at least one packet is waiting
//   grantType          : highest-priority waiting packet (combinational)
module hdmi_packet_arbiter
  import hdmi_island_scheduler_pkg::*;
(
  input  logic        pixelClock,
  input  logic        resetN,
  input  logic        acrRequest,
  input  logic        vSyncRise,
  input  logic [3:0]  sampleCount,
  input  logic        grantTake,
  output logic        anyPending,
  output packetType_e grantType
);

  logic acrPend;
  logic aviPend;
  logic aifPend;
  logic spdPend;
  logic audioReady;

  assign audioReady = (sampleCount != 4'd0);
  assign anyPending = acrPend | audioReady | aviPend | aifPend | spdPend;

  always_comb begin
    grantType = PKT_NULL;
    if (acrPend)         grantType = PKT_ACR;
    else if (audioReady) grantType = PKT_AUDIO;
    else if (aviPend)    grantType = PKT_AVI;
    else if (aifPend)    grantType = PKT_AUDIO_IF;
    else if (spdPend)    grantType = PKT_SPD;
  end

  // A new request arriving in the same cycle as the clear keeps the flag set.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      acrPend <= 1'b0;
      aviPend <= 1'b0;
      aifPend <= 1'b0;
      spdPend <= 1'b0;
    end else begin
      acrPend <= acrRequest | (acrPend & ~(grantTake & (grantType == PKT_ACR)));
      aviPend <= vSyncRise  | (aviPend & ~(grantTake & (grantType == PKT_AVI)));
      aifPend <= vSyncRise  | (aifPend & ~(grantTake & (grantType == PKT_AUDIO_IF)));
      spdPend <= vSyncRise  | (spdPend & ~(grantTake & (grantType == PKT_SPD)));
    end
  end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island scheduler: places data islands in blanking and emits
// registered per-pixel framing for the packet assembler / TERC4 datapath.
//   pixelClock, resetN : clock and async active-low reset
//   dataEnable         : active video; rising inside an island aborts it
//   vSync              : rising edge arms the per-frame InfoFrames
//   blankRemaining     : pixels left before the next active line
//   acrRequest         : ACR packet due (pulse)
//   sampleCount        : audio FIFO level
//   preamble, guardBand, packetActive, packetStart : island framing strobes
//   packetType, packetPixel, packetSamples         : slot content and position
//
// state        | meaning
// ST_IDLE      | control period; counts ctrl pixels, waits for work that fits
// ST_PREAMBLE  | 8 data-island preamble pixels
// ST_LEAD_GUARD| 2 leading guard-band pixels
// ST_PACKET    | 32-pixel packet slot, possibly several back-to-back
// ST_TRAIL_GUARD| 2 trailing guard-band pixels, then back to control
module hdmi_island_scheduler
  import hdmi_island_scheduler_pkg::*;
#(
  parameter int MAX_PACKETS = 18,
  parameter int MIN_CTRL    = 12,
  parameter int RESERVE     = 22
) (
  input  logic        pixelClock,
  input  logic        resetN,
  input  logic        dataEnable,
  input  logic        vSync,
  input  logic [11:0] blankRemaining,
  input  logic        acrRequest,
  input  logic [3:0]  sampleCount,
  output logic        preamble,
  output logic        guardBand,
  output logic        packetActive,
  output logic        packetStart,
  output logic [2:0]  packetType,
  output logic [4:0]  packetPixel,
  output logic [2:0]  packetSamples
);

  localparam int CTRL_W = $clog2(MIN_CTRL + 1);
  localparam int PKT_W  = $clog2(MAX_PACKETS + 1);
  localparam logic [11:0] FIT_FIRST = 12'(ISLAND_OVERHEAD + SLOT_LEN + RESERVE);
  // Another slot plus the trailing guard must still clear the reserve.
  localparam logic [11:0] FIT_NEXT  = 12'(SLOT_LEN + GUARD_LEN + RESERVE);

  islandState_e state, stateNext;
  logic [4:0]        phaseCount, phaseNext;
  logic [PKT_W-1:0]  packetCount, packetCountNext;
  logic [CTRL_W-1:0] ctrlCount;
  logic              vSyncQ;

  logic        anyPending;
  packetType_e grantType;
  logic        grantTake;
  logic        ctrlFull;
  logic        canChain;
  logic        atBoundary;

  logic        preambleD, guardD, activeD, startD;
  packetType_e typeD;
  logic [4:0]  pixelD;
  logic [2:0]  samplesD;

  hdmi_packet_arbiter uArbiter (
    .pixelClock  (pixelClock),
    .resetN      (resetN),
    .acrRequest  (acrRequest),
    .vSyncRise   (vSync & ~vSyncQ),
    .sampleCount (sampleCount),
    .grantTake   (grantTake),
    .anyPending  (anyPending),
    .grantType   (grantType)
  );

  assign ctrlFull = (ctrlCount == CTRL_W'(MIN_CTRL));
  assign canChain = anyPending && (packetCount < PKT_W'(MAX_PACKETS))
                    && (blankRemaining >= FIT_NEXT);

  always_comb begin
    stateNext       = state;
    phaseNext       = phaseCount;
    packetCountNext = packetCount;
    grantTake       = 1'b0;
    atBoundary      = 1'b0;
    preambleD       = 1'b0;
    guardD          = 1'b0;
    activeD         = 1'b0;
    startD          = 1'b0;
    typeD           = PKT_NULL;
    pixelD          = 5'd0;
    samplesD        = 3'd0;

    case (state)
      ST_IDLE: begin
        if (!dataEnable && ctrlFull && anyPending && (blankRemaining >= FIT_FIRST)) begin
          stateNext       = ST_PREAMBLE;
          phaseNext       = 5'd0;
          packetCountNext = '0;
          preambleD       = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (phaseCount == 5'(PREAMBLE_LEN - 1)) begin
          stateNext = ST_LEAD_GUARD;
          phaseNext = 5'd0;
          guardD    = 1'b1;
        end else begin
          phaseNext = phaseCount + 5'd1;
          preambleD = 1'b1;
        end
      end
      ST_LEAD_GUARD: begin
        if (phaseCount == 5'(GUARD_LEN - 1)) begin
          atBoundary = 1'b1;
        end else begin
          phaseNext = phaseCount + 5'd1;
          guardD    = 1'b1;
        end
      end
      ST_PACKET: begin
        if (phaseCount == 5'(SLOT_LEN - 1)) begin
          atBoundary = 1'b1;
        end else begin
          phaseNext = phaseCount + 5'd1;
          activeD   = 1'b1;
          pixelD    = phaseCount + 5'd1;
          typeD     = packetType_e'(packetType);
          samplesD  = packetSamples;
        end
      end
      ST_TRAIL_GUARD: begin
        if (phaseCount == 5'(GUARD_LEN - 1)) begin
          stateNext = ST_IDLE;
          phaseNext = 5'd0;
        end else begin
          phaseNext = phaseCount + 5'd1;
          guardD    = 1'b1;
        end
      end
      default: begin
        stateNext = ST_IDLE;
        phaseNext = 5'd0;
      end
    endcase

    // Slot boundary: chain another packet or close the island.
    if (atBoundary) begin
      phaseNext = 5'd0;
      if (canChain) begin
        stateNext       = ST_PACKET;
        packetCountNext = packetCount + PKT_W'(1);
        grantTake       = 1'b1;
        activeD         = 1'b1;
        startD          = 1'b1;
        typeD           = grantType;
        samplesD        = (grantType == PKT_AUDIO) ? audioSamples(sampleCount) : 3'd0;
      end else begin
        stateNext = ST_TRAIL_GUARD;
        guardD    = 1'b1;
      end
    end

    // Active video inside an island is a timing error: drop everything but
    // leave pending flags alone so the work goes out in the next island.
    if (dataEnable && (state != ST_IDLE)) begin
      stateNext       = ST_IDLE;
      phaseNext       = 5'd0;
      packetCountNext = '0;
      grantTake       = 1'b0;
      preambleD       = 1'b0;
      guardD          = 1'b0;
      activeD         = 1'b0;
      startD          = 1'b0;
      typeD           = PKT_NULL;
      pixelD          = 5'd0;
      samplesD        = 3'd0;
    end
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state         <= ST_IDLE;
      phaseCount    <= 5'd0;
      packetCount   <= '0;
      ctrlCount     <= '0;
      vSyncQ        <= 1'b0;
      preamble      <= 1'b0;
      guardBand     <= 1'b0;
      packetActive  <= 1'b0;
      packetStart   <= 1'b0;
      packetType    <= 3'd0;
      packetPixel   <= 5'd0;
      packetSamples <= 3'd0;
    end else begin
      state         <= stateNext;
      phaseCount    <= phaseNext;
      packetCount   <= packetCountNext;
      vSyncQ        <= vSync;
      preamble      <= preambleD;
      guardBand     <= guardD;
      packetActive  <= activeD;
      packetStart   <= startD;
      packetType    <= typeD;
      packetPixel   <= pixelD;
      packetSamples <= samplesD;
      if (dataEnable || (state != ST_IDLE)) begin
        ctrlCount <= '0;
      end else if (!ctrlFull) begin
        ctrlCount <= ctrlCount + CTRL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for hdmi_island_scheduler: drives blanking/requests, captures
// each island's framing and compares it with hand-computed expectations.
module tb_hdmi_island_scheduler;

  logic        pixelClock;
  logic        resetN;
  logic        dataEnable;
  logic        vSync;
  logic [11:0] blankRemaining;
  logic        acrRequest;
  logic [3:0]  sampleCount;
  logic        preamble;
  logic        guardBand;
  logic        packetActive;
  logic        packetStart;
  logic [2:0]  packetType;
  logic [4:0]  packetPixel;
  logic [2:0]  packetSamples;

  hdmi_island_scheduler dut (
    .pixelClock    (pixelClock),
    .resetN        (resetN),
    .dataEnable    (dataEnable),
    .vSync         (vSync),
    .blankRemaining(blankRemaining),
    .acrRequest    (acrRequest),
    .sampleCount   (sampleCount),
    .preamble      (preamble),
    .guardBand     (guardBand),
    .packetActive  (packetActive),
    .packetStart   (packetStart),
    .packetType    (packetType),
    .packetPixel   (packetPixel),
    .packetSamples (packetSamples)
  );

  initial pixelClock = 1'b0;
  always #5 pixelClock = ~pixelClock;

  int errors = 0;
  int checks = 0;
  bit blankAuto = 1'b0;
  int fifoLevel = 0;

  int capWait, capPre, capLead, capTrail, capSlots, capSeqErr, capTimeout;
  int capTypes[32];
  int capSamples[32];
  int slotPix, slotType;

  function automatic int outWord();
    return int'({preamble, guardBand, packetActive, packetStart,
                 packetType, packetPixel, packetSamples});
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge pixelClock);
    #1;
    if (blankAuto && blankRemaining != 12'd0) blankRemaining = blankRemaining - 12'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulseAcr();
    acrRequest = 1'b1;
    tick();
    acrRequest = 1'b0;
  endtask

  // Records a new slot; plays the assembler by popping audio samples.
  task automatic takeSlot();
    if (packetPixel != 5'd0) capSeqErr++;
    if (capSlots < 32) begin
      capTypes[capSlots]   = int'(packetType);
      capSamples[capSlots] = int'(packetSamples);
    end
    capSlots++;
    slotType = int'(packetType);
    slotPix  = 1;
    if (packetType == 3'd2) begin
      fifoLevel   = fifoLevel - int'(packetSamples);
      sampleCount = 4'((fifoLevel > 15) ? 15 : fifoLevel);
    end
  endtask

  task automatic capture(input int budget);
    int  mode;
    bit  done;
    capWait = 0; capPre = 0; capLead = 0; capTrail = 0;
    capSlots = 0; capSeqErr = 0; capTimeout = 0;
    for (int i = 0; i < 32; i++) begin
      capTypes[i] = -1;
      capSamples[i] = -1;
    end
    mode = 0; done = 1'b0; slotPix = 0; slotType = 0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      case (mode)
        0: if (preamble) begin mode = 1; capPre = 1; end
           else if (outWord() != 0) begin capSeqErr++; done = 1'b1; end
           else capWait++;
        1: if (preamble) capPre++;
           else if (guardBand) begin mode = 2; capLead = 1; end
           else begin capSeqErr++; done = 1'b1; end
        2: if (packetStart) begin mode = 3; takeSlot(); end
           else if (guardBand) capLead++;
           else begin capSeqErr++; done = 1'b1; end
        3: if (packetStart) begin
             if (slotPix != 32) capSeqErr++;
             takeSlot();
           end else if (packetActive) begin
             if (int'(packetPixel) != slotPix || int'(packetType) != slotType) capSeqErr++;
             slotPix++;
           end else if (guardBand) begin
             if (slotPix != 32) capSeqErr++;
             mode = 4; capTrail = 1;
           end else begin capSeqErr++; done = 1'b1; end
        default: if (guardBand) capTrail++;
           else if (outWord() == 0) done = 1'b1;
           else begin capSeqErr++; done = 1'b1; end
      endcase
    end
    if (!done) capTimeout = 1;
  endtask

  task automatic waitPixel(input int pix, input string tag);
    for (int c = 0; c < 100 && !(packetActive && int'(packetPixel) == pix); c++) tick();
    check(tag, int'(packetPixel), pix);
  endtask

  initial begin
    int preSeen;
    resetN = 1'b0; dataEnable = 1'b0; vSync = 1'b0; blankRemaining = 12'd0;
    acrRequest = 1'b0; sampleCount = 4'd0;

    #12;
    check("reset_outputs", outWord(), 0);
    tick();
    resetN = 1'b1;
    idle(15);
    check("idle_outputs", outWord(), 0);

    // Single ACR island.
    blankRemaining = 12'd370;
    pulseAcr();
    capture(200);
    check("acr_wait", capWait, 0);
    check("acr_preamble", capPre, 8);
    check("acr_lead", capLead, 2);
    check("acr_slots", capSlots, 1);
    check("acr_type", capTypes[0], 1);
    check("acr_samples", capSamples[0], 0);
    check("acr_trail", capTrail, 2);
    check("acr_seq", capSeqErr + capTimeout, 0);
    idle(15);

    // vSync InfoFrames plus six audio samples.
    blankRemaining = 12'd700; blankAuto = 1'b1;
    fifoLevel = 6; sampleCount = 4'd6; vSync = 1'b1;
    capture(300);
    vSync = 1'b0; blankAuto = 1'b0;
    check("mix_slots", capSlots, 5);
    check("mix_type0", capTypes[0], 2);
    check("mix_samp0", capSamples[0], 4);
    check("mix_type1", capTypes[1], 2);
    check("mix_samp1", capSamples[1], 2);
    check("mix_type2", capTypes[2], 3);
    check("mix_type3", capTypes[3], 4);
    check("mix_type4", capTypes[4], 5);
    check("mix_samp4", capSamples[4], 0);
    check("mix_seq", capSeqErr + capTimeout, 0);
    idle(15);

    // Fit boundary: 65 is one short, 66 just fits.
    blankRemaining = 12'd65;
    pulseAcr();
    preSeen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (preamble || guardBand || packetActive) preSeen++;
    end
    check("fit65_no_island", preSeen, 0);
    blankRemaining = 12'd66; blankAuto = 1'b1;
    capture(200);
    blankAuto = 1'b0;
    check("fit66_wait", capWait, 0);
    check("fit66_slots", capSlots, 1);
    check("fit66_type", capTypes[0], 1);
    check("fit66_trail", capTrail, 2);
    check("fit66_seq", capSeqErr + capTimeout, 0);
    idle(15);

    // Twenty audio packets: 18 in one island, the remaining 2 after 12 ctrl.
    blankRemaining = 12'd2000;
    fifoLevel = 80; sampleCount = 4'd15;
    capture(800);
    check("max_slots", capSlots, 18);
    check("max_type_last", capTypes[17], 2);
    check("max_samp_last", capSamples[17], 4);
    check("max_trail", capTrail, 2);
    check("max_seq", capSeqErr + capTimeout, 0);
    capture(200);
    check("rest_wait", capWait, 12);
    check("rest_slots", capSlots, 2);
    check("rest_samp1", capSamples[1], 4);
    check("rest_seq", capSeqErr + capTimeout, 0);
    check("rest_fifo", fifoLevel, 0);
    idle(15);

    // dataEnable rises mid-slot: abort, ACR re-requested during the slot survives.
    blankRemaining = 12'd370;
    pulseAcr();
    waitPixel(3, "abort_reach3");
    pulseAcr();
    waitPixel(10, "abort_reach10");
    dataEnable = 1'b1; blankRemaining = 12'd0;
    tick();
    check("abort_outputs", outWord(), 0);
    dataEnable = 1'b0; blankRemaining = 12'd370;
    capture(200);
    check("abort_wait", capWait, 12);
    check("abort_slots", capSlots, 1);
    check("abort_type", capTypes[0], 1);
    check("abort_seq", capSeqErr + capTimeout, 0);
    idle(15);

    // Asynchronous reset in the middle of a packet slot.
    pulseAcr();
    waitPixel(5, "rst_reach5");
    resetN = 1'b0;
    #1;
    check("rst_mid_outputs", outWord(), 0);
    tick();
    tick();
    resetN = 1'b1;
    pulseAcr();
    capture(200);
    check("rst_wait", capWait, 11);
    check("rst_slots", capSlots, 1);
    check("rst_type", capTypes[0], 1);
    check("rst_seq", capSeqErr + capTimeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
